// File: rtl/alu_pkg.sv
// Shared definitions for the ALU status-flag consumers: flag layout,
// branch condition codes, branch FSM states and the condition evaluator.
package alu_pkg;

  localparam int unsigned FLAG_W = 3;
  localparam int unsigned COND_W = 3;

  localparam int unsigned FLAG_Z = 0;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 2;

  localparam logic [COND_W-1:0] COND_ALWAYS = 3'b000;
  localparam logic [COND_W-1:0] COND_Z      = 3'b001;
  localparam logic [COND_W-1:0] COND_NZ     = 3'b010;
  localparam logic [COND_W-1:0] COND_C      = 3'b011;
  localparam logic [COND_W-1:0] COND_NC     = 3'b100;
  localparam logic [COND_W-1:0] COND_V      = 3'b101;
  localparam logic [COND_W-1:0] COND_NV     = 3'b110;
  localparam logic [COND_W-1:0] COND_NEVER  = 3'b111;

  typedef logic [FLAG_W-1:0] flags_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } br_state_e;

  // Resolve a condition code against a {V, C, Z} flag vector.
  function automatic logic cond_eval(input logic [COND_W-1:0] cond, input flags_t f);
    logic res;
    res = 1'b0;
    case (cond)
      COND_ALWAYS: res = 1'b1;
      COND_Z:      res = f[FLAG_Z];
      COND_NZ:     res = ~f[FLAG_Z];
      COND_C:      res = f[FLAG_C];
      COND_NC:     res = ~f[FLAG_C];
      COND_V:      res = f[FLAG_V];
      COND_NV:     res = ~f[FLAG_V];
      COND_NEVER:  res = 1'b0;
      default:     res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/flag_branch_unit_if.sv
// Branch request/response channel between the sequencer (master) and the
// flag/branch unit (slave).
interface flag_branch_unit_if #(
  parameter int unsigned PC_W = 8
);

  logic                        br_valid;
  logic                        br_ready;
  logic [alu_pkg::COND_W-1:0]  br_cond;
  logic [PC_W-1:0]             br_pc;
  logic [PC_W-1:0]             br_target;
  logic                        rsp_valid;
  logic                        rsp_ready;
  logic                        rsp_taken;
  logic [PC_W-1:0]             rsp_next_pc;

  modport master (
    output br_valid, br_cond, br_pc, br_target, rsp_ready,
    input  br_ready, rsp_valid, rsp_taken, rsp_next_pc
  );

  modport slave (
    input  br_valid, br_cond, br_pc, br_target, rsp_ready,
    output br_ready, rsp_valid, rsp_taken, rsp_next_pc
  );

endinterface

// File: rtl/flag_branch_unit_flag_stack.sv
// LIFO of saved flag vectors for interrupt entry/return. Simultaneous push
// and pop is a no-op; overflow/underflow leave the stack intact and set err.
module flag_stack
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  logic   pop,
  input  flags_t din,
  output flags_t top_c,
  output logic   full,
  output logic   empty,
  output logic   err
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = IDX_W + 1;

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             do_push;
  logic             do_pop;
  logic             bad_op;
  flags_t           mem [DEPTH];

  always_comb begin
    do_push = push & ~pop & ~full;
    do_pop  = pop & ~push & ~empty;
    bad_op  = (push & ~pop & full) | (pop & ~push & empty);
    cnt_nxt = cnt;
    if (do_push) begin
      cnt_nxt = cnt + CNT_W'(1);
    end else if (do_pop) begin
      cnt_nxt = cnt - CNT_W'(1);
    end
  end

  // Status flags are registered alongside the count so they are glitch-free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
      err   <= 1'b0;
    end else begin
      cnt   <= cnt_nxt;
      full  <= (cnt_nxt == CNT_W'(DEPTH));
      empty <= (cnt_nxt == '0);
      err   <= err | bad_op;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[cnt[IDX_W-1:0]] <= din;
    end
  end

  // Index wraps harmlessly when empty; callers gate on empty.
  assign top_c = mem[IDX_W'(cnt - CNT_W'(1))];

endmodule

// File: rtl/flag_branch_unit.sv
// Latches ALU status flags, saves/restores them on a small stack and resolves
// conditional branches against the (forwarded) flags via a valid/ready pair.
module flag_branch_unit
  import alu_pkg::*;
#(
  parameter int unsigned PC_W      = 8,
  parameter int unsigned STK_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                alu_zero,
  input  logic                alu_carry,
  input  logic                alu_overflow,
  input  logic                flag_we,
  input  logic                push,
  input  logic                pop,
  flag_branch_unit_if.slave   bus,
  output logic [FLAG_W-1:0]   flags,
  output logic                stk_full,
  output logic                stk_empty,
  output logic                stk_err
);

  flags_t          alu_flags;
  flags_t          stk_top_c;
  flags_t          flags_nxt;
  logic            pop_ok;

  br_state_e       state;
  br_state_e       state_nxt;
  logic            br_ready_q;
  logic            br_ready_nxt;
  logic            rsp_valid_q;
  logic            rsp_valid_nxt;
  logic            rsp_taken_q;
  logic            rsp_taken_nxt;
  logic [PC_W-1:0] rsp_next_pc_q;
  logic [PC_W-1:0] rsp_next_pc_nxt;
  logic            taken_c;

  assign alu_flags = {alu_overflow, alu_carry, alu_zero};

  // Next flag value: a successful pop wins over an ALU load.
  always_comb begin
    pop_ok    = pop & ~push & ~stk_empty;
    flags_nxt = flags;
    if (pop_ok) begin
      flags_nxt = stk_top_c;
    end else if (flag_we) begin
      flags_nxt = alu_flags;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags <= '0;
    end else begin
      flags <= flags_nxt;
    end
  end

  flag_stack #(
    .DEPTH (STK_DEPTH)
  ) u_flag_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (flags),
    .top_c (stk_top_c),
    .full  (stk_full),
    .empty (stk_empty),
    .err   (stk_err)
  );

  // Branch FSM next-state and registered response outputs.
  always_comb begin
    state_nxt       = state;
    br_ready_nxt    = br_ready_q;
    rsp_valid_nxt   = rsp_valid_q;
    rsp_taken_nxt   = rsp_taken_q;
    rsp_next_pc_nxt = rsp_next_pc_q;
    taken_c         = cond_eval(bus.br_cond, flags_nxt);
    case (state)
      ST_IDLE: begin
        if (bus.br_valid) begin
          state_nxt       = ST_RESP;
          br_ready_nxt    = 1'b0;
          rsp_valid_nxt   = 1'b1;
          rsp_taken_nxt   = taken_c;
          rsp_next_pc_nxt = taken_c ? bus.br_target : bus.br_pc + PC_W'(1);
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          state_nxt     = ST_IDLE;
          br_ready_nxt  = 1'b1;
          rsp_valid_nxt = 1'b0;
        end
      end
      default: begin
        state_nxt     = ST_IDLE;
        br_ready_nxt  = 1'b1;
        rsp_valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      br_ready_q    <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_taken_q   <= 1'b0;
      rsp_next_pc_q <= '0;
    end else begin
      state         <= state_nxt;
      br_ready_q    <= br_ready_nxt;
      rsp_valid_q   <= rsp_valid_nxt;
      rsp_taken_q   <= rsp_taken_nxt;
      rsp_next_pc_q <= rsp_next_pc_nxt;
    end
  end

  assign bus.br_ready    = br_ready_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_taken   = rsp_taken_q;
  assign bus.rsp_next_pc = rsp_next_pc_q;

endmodule

// File: tb/tb_flag_branch_unit.sv
// Bench for flag_branch_unit: directed scenarios plus random traffic against
// a queue-based reference model of flags, stack and branch handshake.
module tb_flag_branch_unit;

  localparam int unsigned PC_W  = 8;
  localparam int unsigned DEPTH = 4;

  logic       clk;
  logic       rst;
  logic       alu_zero;
  logic       alu_carry;
  logic       alu_overflow;
  logic       flag_we;
  logic       push;
  logic       pop;
  logic [2:0] flags;
  logic       stk_full;
  logic       stk_empty;
  logic       stk_err;

  flag_branch_unit_if #(.PC_W(PC_W)) bif ();

  flag_branch_unit #(
    .PC_W      (PC_W),
    .STK_DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .alu_zero     (alu_zero),
    .alu_carry    (alu_carry),
    .alu_overflow (alu_overflow),
    .flag_we      (flag_we),
    .push         (push),
    .pop          (pop),
    .bus          (bif),
    .flags        (flags),
    .stk_full     (stk_full),
    .stk_empty    (stk_empty),
    .stk_err      (stk_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  // reference model state
  logic [2:0] m_flags;
  logic [2:0] m_stk[$];
  logic       m_err;
  logic       m_busy;
  logic       m_taken;
  logic [7:0] m_npc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic cond_true(input logic [2:0] cc, input logic [2:0] f);
    logic z, c, v;
    z = f[0];
    c = f[1];
    v = f[2];
    case (cc)
      3'd0: return 1'b1;
      3'd1: return z;
      3'd2: return !z;
      3'd3: return c;
      3'd4: return !c;
      3'd5: return v;
      3'd6: return !v;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    m_flags = 3'b000;
    m_stk.delete();
    m_err   = 1'b0;
    m_busy  = 1'b0;
    m_taken = 1'b0;
    m_npc   = 8'h00;
  endtask

  // Advance the model by one clock using the currently driven inputs.
  task automatic model_step();
    logic       was_busy;
    logic       popped;
    was_busy = m_busy;
    popped   = 1'b0;
    if (push && !pop) begin
      if (m_stk.size() == DEPTH) m_err = 1'b1;
      else m_stk.push_back(m_flags);
    end else if (pop && !push) begin
      if (m_stk.size() == 0) m_err = 1'b1;
      else begin
        m_flags = m_stk.pop_back();
        popped  = 1'b1;
      end
    end
    if (!popped && flag_we) m_flags = {alu_overflow, alu_carry, alu_zero};
    if (!was_busy && bif.br_valid) begin
      m_busy  = 1'b1;
      m_taken = cond_true(bif.br_cond, m_flags);
      m_npc   = m_taken ? bif.br_target : bif.br_pc + 8'd1;
    end else if (was_busy && bif.rsp_ready) begin
      m_busy = 1'b0;
    end
  endtask

  task automatic check_state();
    check("flags", 32'(flags), 32'(m_flags));
    check("stk_full", 32'(stk_full), 32'(m_stk.size() == DEPTH));
    check("stk_empty", 32'(stk_empty), 32'(m_stk.size() == 0));
    check("stk_err", 32'(stk_err), 32'(m_err));
    check("br_ready", 32'(bif.br_ready), 32'(!m_busy));
    check("rsp_valid", 32'(bif.rsp_valid), 32'(m_busy));
    if (m_busy) begin
      check("rsp_taken", 32'(bif.rsp_taken), 32'(m_taken));
      check("rsp_next_pc", 32'(bif.rsp_next_pc), 32'(m_npc));
    end
  endtask

  // Drive one cycle of inputs (at negedge), step the model, check next negedge.
  task automatic cyc(input logic we, input logic [2:0] alu, input logic ps, input logic pp,
                     input logic bv, input logic [2:0] bc, input logic [7:0] bpc,
                     input logic [7:0] bt, input logic rr);
    flag_we         = we;
    {alu_overflow, alu_carry, alu_zero} = alu;
    push            = ps;
    pop             = pp;
    bif.br_valid    = bv;
    bif.br_cond     = bc;
    bif.br_pc       = bpc;
    bif.br_target   = bt;
    bif.rsp_ready   = rr;
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_state();
  endtask

  task automatic idle(input logic rr);
    cyc(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00, rr);
  endtask

  // Reset pulse applied between edges; outputs must clear without a clock.
  task automatic pulse_reset();
    flag_we = 1'b0; push = 1'b0; pop = 1'b0;
    bif.br_valid = 1'b0; bif.rsp_ready = 1'b0;
    rst = 1'b1;
    #1;
    model_reset();
    check("rst_rsp_valid", 32'(bif.rsp_valid), 32'd0);
    check("rst_br_ready", 32'(bif.br_ready), 32'd1);
    check("rst_flags", 32'(flags), 32'd0);
    check("rst_stk_empty", 32'(stk_empty), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    idle(1'b0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst = 1'b1;
    flag_we = 1'b0; alu_zero = 1'b0; alu_carry = 1'b0; alu_overflow = 1'b0;
    push = 1'b0; pop = 1'b0;
    bif.br_valid = 1'b0; bif.br_cond = 3'd0; bif.br_pc = 8'h00;
    bif.br_target = 8'h00; bif.rsp_ready = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check("reset_taken", 32'(bif.rsp_taken), 32'd0);
    check("reset_next_pc", 32'(bif.rsp_next_pc), 32'd0);
    check_state();
    rst = 1'b0;
    idle(1'b0);

    // Z branch after an ALU load, held while not consumed
    cyc(1'b1, 3'b001, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
    cyc(1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 3'd1, 8'h10, 8'h40, 1'b0);
    check("tp1_taken", 32'(bif.rsp_taken), 32'd1);
    check("tp1_next_pc", 32'(bif.rsp_next_pc), 32'h40);
    idle(1'b0);
    idle(1'b0);
    check("tp1_held", 32'(bif.rsp_next_pc), 32'h40);
    idle(1'b1);

    // forwarded flags: C set in the acceptance cycle, branch on !C
    cyc(1'b1, 3'b010, 1'b0, 1'b0, 1'b1, 3'd4, 8'h20, 8'h80, 1'b0);
    check("tp2_taken", 32'(bif.rsp_taken), 32'd0);
    check("tp2_next_pc", 32'(bif.rsp_next_pc), 32'h21);
    idle(1'b1);

    // fill the stack, overflow, then drain in reverse order
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 3'(i + 2), 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
      cyc(1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
    end
    cyc(1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
    check("tp3_full", 32'(stk_full), 32'd1);
    check("tp3_err", 32'(stk_err), 32'd1);
    for (int k = 0; k < 4; k++) begin
      cyc(1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
      check("tp3_pop_flags", 32'(flags), 32'(5 - k));
    end
    check("tp3_empty", 32'(stk_empty), 32'd1);
    pulse_reset();

    // underflow leaves flags alone and err is sticky
    cyc(1'b1, 3'b110, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
    cyc(1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
    check("tp4_flags", 32'(flags), 32'b110);
    for (int k = 0; k < 3; k++) idle(1'b0);
    check("tp4_err_sticky", 32'(stk_err), 32'd1);

    // never-taken at pc 0xFF wraps; reset during the response
    cyc(1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 3'd7, 8'hFF, 8'h33, 1'b0);
    check("tp6_next_pc", 32'(bif.rsp_next_pc), 32'h00);
    pulse_reset();

    // simultaneous push and pop with an ALU load
    cyc(1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
    cyc(1'b1, 3'b101, 1'b1, 1'b1, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
    check("tp5_flags", 32'(flags), 32'b101);
    check("tp5_err", 32'(stk_err), 32'd0);
    check("tp5_depth", 32'(stk_empty), 32'd0);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      if (n % 500 == 499) begin
        @(negedge clk);
        pulse_reset();
      end else begin
        cyc(($urandom_range(0, 2) == 0), 3'($urandom_range(0, 7)),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 1) == 0), 3'($urandom_range(0, 7)),
            8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
            ($urandom_range(0, 2) != 0));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/flag_branch_unit.md
# flag_branch_unit

Consumer side of the ALU status flags. Latches the zero/carry/overflow flags produced alongside each ALU result, keeps a small save/restore stack of them for interrupt entry/return, and resolves conditional branches from the sequencer against the current flags through a valid/ready request/response handshake. Sits between the ALU and the program-counter logic of the 8-bit processor.

## Interface
- `PC_W`, 8, program-counter / branch-target width
- `STK_DEPTH`, 4, flag-stack entries (power of two, ≥2)

- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `alu_zero`, `alu_carry`, `alu_overflow`  in  1 each  flags from the ALU status logic
- `flag_we`  in  1  load ALU flags into the flag register this cycle
- `push`  in  1  save current flags onto the stack
- `pop`  in  1  restore flags from top of stack
- `br_valid`  in  1  branch request
- `br_ready`  out  1  unit can accept a request
- `br_cond`  in  3  condition code
- `br_pc`  in  PC_W  PC of the branch instruction
- `br_target`  in  PC_W  taken target
- `rsp_valid`  out  1  resolution available
- `rsp_ready`  in  1  sequencer consumes resolution
- `rsp_taken`  out  1  condition true
- `rsp_next_pc`  out  PC_W  `br_target` if taken, else `br_pc + 1` (mod 2^PC_W)
- `flags`  out  3  current {V, C, Z}
- `stk_full`, `stk_empty`  out  1 each  stack status
- `stk_err`  out  1  sticky: push when full or pop when empty

## Operation
- Flag register next value, priority: pop (non-empty, no simultaneous push) → top of stack; else `flag_we` → ALU flags; else hold.
- Stack: push stores current `flags` register value (pre-update). Push when full, or pop when empty: stack and flags unchanged, `stk_err` set; `stk_err` clears only on reset. Push and pop together: no-op on stack and no error; `flag_we` still applies.
- Condition codes: 000 always; 001 Z; 010 !Z; 011 C (unsigned a ≥ b after SUB); 100 !C; 101 V; 110 !V; 111 never.
- Forwarding: a request accepted in a cycle where the flag register is updated is evaluated against the next value (popped or ALU flags), not the stale one.
- FSM: IDLE (`br_ready`=1) → on `br_valid` capture cond-evaluated `taken` and `next_pc`, go RESP. RESP (`br_ready`=0, `rsp_valid`=1, outputs stable) → on `rsp_ready` go IDLE. No back-to-back acceptance in the RESP-exit cycle.
- Flags changing while in RESP do not alter the held response.

## Timing
- Reset values: `flags`=000, stack empty (`stk_empty`=1, `stk_full`=0), `stk_err`=0, state IDLE, `br_ready`=1, `rsp_valid`=0, `rsp_taken`=0, `rsp_next_pc`=0.
- Flag register, stack, err: update on the edge of the cycle the input is asserted; visible the next cycle.
- Branch latency: request accepted at edge N → `rsp_valid` from cycle N+1; throughput one branch per two cycles minimum.
- `rst` asserted mid-response: `rsp_valid` drops immediately (asynchronous), pending response discarded, stack contents lost.
- `br_pc` = 2^PC_W−1 not taken → `rsp_next_pc` = 0.

## Structure
- Shared package `alu_pkg`: condition-code constants (`COND_ALWAYS` … `COND_NEVER`), flag bit indices (`FLAG_Z`=0, `FLAG_C`=1, `FLAG_V`=2), FSM state enum.
- One sub-module: `flag_stack` (LIFO, depth `STK_DEPTH`, 3-bit entries, push/pop/full/empty/err); condition evaluation and FSM stay in the top.

## Test plan
- `flag_we` with Z=1,C=0,V=0, then branch cond 001, pc 0x10, target 0x40 → next cycle `rsp_valid`=1, taken=1, next_pc=0x40; held while `rsp_ready`=0.
- Same cycle `flag_we` (C=1) and accepted branch cond 100 → taken=0, next_pc=pc+1 (forwarded flags used).
- Push 4 times with distinct flag values, 5th push → `stk_full`=1, `stk_err`=1, stack unchanged; 4 pops restore values in reverse order, then `stk_empty`=1.
- Pop on empty → flags unchanged, `stk_err`=1 and stays set until reset.
- Push+pop same cycle with `flag_we` → stack depth unchanged, flags = ALU flags, no error.
- Branch cond 111, pc 0xFF, then `rst` pulse during RESP → `rsp_valid`=0 immediately, `br_ready`=1 after release, all flags 000.
